// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/status bundle between the multicycle controller and its datapath
interface multicycle_ctrl_if #(parameter int CNT_W = 16);
  logic run;
  logic [5:0] opcode;
  logic alu_zero, alu_ovf;
  logic [3:0] state;
  logic pc_write, ir_write, reg_write, reg_dst, mem_read, mem_write, mem2reg, alu_src_a;
  logic [1:0] pc_src, alu_src_b, alu_op, cause;
  logic epc_write, instr_done;
  logic [CNT_W-1:0] instr_count;
  modport master(output run, opcode, alu_zero, alu_ovf,
                 input state, pc_write, ir_write, reg_write, reg_dst, mem_read, mem_write, mem2reg,
                 alu_src_a, pc_src, alu_src_b, alu_op, epc_write, cause, instr_done, instr_count);
  modport slave(input run, opcode, alu_zero, alu_ovf,
                output state, pc_write, ir_write, reg_write, reg_dst, mem_read, mem_write, mem2reg,
                alu_src_a, pc_src, alu_src_b, alu_op, epc_write, cause, instr_done, instr_count);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: MIPS-style multicycle control FSM; MULTICYCLE_CTRL_EXC_EN enables the exception state
module multicycle_ctrl #(parameter int CNT_W = 16) (
  input logic SYS_clk,
  input logic SYS_reset,
  multicycle_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5, RTEX = 4'd6,
    RTWB = 4'd7, ITEX = 4'd8, ITWB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11, EXC = 4'd12
  } state_t;
  state_t r_state;
  logic [CNT_W-1:0] r_count;
`ifdef MULTICYCLE_CTRL_EXC_EN
  logic [1:0] r_cause;
  assign bus.cause = r_cause;
`else
  assign bus.cause = 2'd0;
`endif
  assign bus.state = r_state;
  assign bus.instr_count = r_count;
  // next-state sequencing, retire counter and exception cause capture
  always_ff @(posedge SYS_clk or posedge SYS_reset)
    if (SYS_reset) begin
      r_state <= FETCH;
      r_count <= '0;
`ifdef MULTICYCLE_CTRL_EXC_EN
      r_cause <= 2'd0;
`endif
    end else begin
      if (bus.instr_done) r_count <= r_count + 1'b1;
      case (r_state)
        FETCH:  r_state <= bus.run ? DECODE : FETCH;
        DECODE:
          case (bus.opcode)
            6'h00:        r_state <= RTEX;
            6'h23, 6'h2B: r_state <= MEMADR;
            6'h08:        r_state <= ITEX;
            6'h04, 6'h05: r_state <= BRANCH;
            6'h02:        r_state <= JUMP;
            default: begin
`ifdef MULTICYCLE_CTRL_EXC_EN
              r_state <= EXC;
              r_cause <= 2'd1;
`else
              r_state <= FETCH;
`endif
            end
          endcase
        MEMADR: r_state <= (bus.opcode == 6'h23) ? MEMRD : MEMWR;
        MEMRD:  r_state <= MEMWB;
`ifdef MULTICYCLE_CTRL_EXC_EN
        RTEX: begin
          r_state <= bus.alu_ovf ? EXC : RTWB;
          if (bus.alu_ovf) r_cause <= 2'd2;
        end
        ITEX: begin
          r_state <= bus.alu_ovf ? EXC : ITWB;
          if (bus.alu_ovf) r_cause <= 2'd2;
        end
`else
        RTEX:   r_state <= RTWB;
        ITEX:   r_state <= ITWB;
`endif
        default: r_state <= FETCH;
      endcase
    end
  // datapath strobes decoded from the current state; reset silences everything, even the FETCH strobes
  always_comb begin
    bus.pc_write = 1'b0;
    bus.ir_write = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_dst = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem2reg = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.pc_src = 2'd0;
    bus.alu_src_b = 2'd0;
    bus.alu_op = 2'b00;
    bus.epc_write = 1'b0;
    bus.instr_done = 1'b0;
    if (!SYS_reset)
      case (r_state)
        FETCH: if (bus.run) begin
          bus.mem_read = 1'b1;
          bus.ir_write = 1'b1;
          bus.alu_src_b = 2'd1;
          bus.pc_write = 1'b1;
        end
        DECODE: bus.alu_src_b = 2'd3;
        MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'd2;
        end
        MEMRD: bus.mem_read = 1'b1;
        MEMWB: begin
          bus.reg_write = 1'b1;
          bus.mem2reg = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEMWR: begin
          bus.mem_write = 1'b1;
          bus.instr_done = 1'b1;
        end
        RTEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op = 2'b10;
        end
        RTWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst = 1'b1;
          bus.instr_done = 1'b1;
        end
        ITEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'd2;
        end
        ITWB: begin
          bus.reg_write = 1'b1;
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op = 2'b01;
          bus.pc_src = 2'd1;
          bus.pc_write = (bus.opcode == 6'h04 && bus.alu_zero) || (bus.opcode == 6'h05 && !bus.alu_zero);
          bus.instr_done = 1'b1;
        end
        JUMP: begin
          bus.pc_src = 2'd2;
          bus.pc_write = 1'b1;
          bus.instr_done = 1'b1;
        end
`ifdef MULTICYCLE_CTRL_EXC_EN
        EXC: begin
          bus.epc_write = 1'b1;
          bus.pc_src = 2'd3;
          bus.pc_write = 1'b1;
        end
`endif
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: path-based reference model of the controller with directed and random stimulus
module tb_multicycle_ctrl;
  localparam int CNT_W = 4;
`ifdef MULTICYCLE_CTRL_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif
  logic clk = 1'b0, SYS_reset;
  multicycle_ctrl_if #(.CNT_W(CNT_W)) b();
  multicycle_ctrl #(.CNT_W(CNT_W)) dut(.SYS_clk(clk), .SYS_reset(SYS_reset), .bus(b));
  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // state visited at step k (0 = DECODE) of an instruction; 0 once it is back in FETCH
  function automatic int path_at(input logic [5:0] op, input bit ovf, input int k);
    int p[4];
    case (op)
      6'h23:        p = '{1, 2, 3, 4};
      6'h2B:        p = '{1, 2, 5, 0};
      6'h00:        p = '{1, 6, (EXC_ON && ovf) ? 12 : 7, 0};
      6'h08:        p = '{1, 8, (EXC_ON && ovf) ? 12 : 9, 0};
      6'h04, 6'h05: p = '{1, 10, 0, 0};
      6'h02:        p = '{1, 11, 0, 0};
      default:      p = '{1, EXC_ON ? 12 : 0, 0, 0};
    endcase
    return (k < 4) ? p[k] : 0;
  endfunction
  function automatic bit known(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02};
  endfunction
  function automatic bit retires(input int s);
    return s inside {4, 5, 7, 9, 10, 11};
  endfunction
  // strobe vector required in state s: {pc_write,ir_write,reg_write,reg_dst,mem_read,mem_write,mem2reg,alu_src_a,pc_src,alu_src_b,alu_op,epc_write,instr_done}
  function automatic logic [15:0] exp_out(input int s, input bit rst, input bit run, input logic [5:0] op, input bit z);
    logic pw, irw, rw, rd, mr, mw, m2r, sa, ep, dn;
    logic [1:0] ps, sb, ao;
    {pw, irw, rw, rd, mr, mw, m2r, sa, ep, dn, ps, sb, ao} = '0;
    case (s)
      0:  if (run) {mr, irw, pw, sb} = {3'b111, 2'd1};
      1:  sb = 2'd3;
      2:  {sa, sb} = {1'b1, 2'd2};
      3:  mr = 1'b1;
      4:  {rw, m2r, dn} = 3'b111;
      5:  {mw, dn} = 2'b11;
      6:  {sa, ao} = {1'b1, 2'b10};
      7:  {rw, rd, dn} = 3'b111;
      8:  {sa, sb} = {1'b1, 2'd2};
      9:  {rw, dn} = 2'b11;
      10: begin
        {sa, ao, ps, dn} = {1'b1, 2'b01, 2'd1, 1'b1};
        pw = (op == 6'h04 && z) || (op == 6'h05 && !z);
      end
      11: {ps, pw, dn} = {2'd2, 1'b1, 1'b1};
      12: {ep, ps, pw} = {1'b1, 2'd3, 1'b1};
      default: ;
    endcase
    return rst ? 16'h0 : {pw, irw, rw, rd, mr, mw, m2r, sa, ps, sb, ao, ep, dn};
  endfunction

  int m_k;
  logic [5:0] m_op;
  bit m_ovf;
  logic [CNT_W-1:0] m_cnt;
  logic [1:0] m_cause;
  function automatic int cur_st();
    return (m_k == 0) ? 0 : path_at(m_op, m_ovf, m_k - 1);
  endfunction
  // reference model: position along the current instruction's path
  always @(posedge clk or posedge SYS_reset)
    if (SYS_reset) begin
      m_k <= 0;
      m_cnt <= '0;
      m_cause <= 2'd0;
    end else if (m_k == 0) begin
      if (b.run) begin
        m_k <= 1;
        m_op <= b.opcode;
        m_ovf <= b.alu_ovf;
      end
    end else begin
      if (retires(cur_st())) m_cnt <= m_cnt + 1'b1;
      m_k <= (path_at(m_op, m_ovf, m_k) == 0) ? 0 : m_k + 1;
      if (path_at(m_op, m_ovf, m_k) == 12) m_cause <= known(m_op) ? 2'd2 : 2'd1;
    end
  // compare every cycle away from the active edge
  always @(negedge clk) begin
    chk("state", b.state, cur_st());
    chk("strobes", {b.pc_write, b.ir_write, b.reg_write, b.reg_dst, b.mem_read, b.mem_write, b.mem2reg,
        b.alu_src_a, b.pc_src, b.alu_src_b, b.alu_op, b.epc_write, b.instr_done},
        exp_out(cur_st(), SYS_reset, b.run, b.opcode, b.alu_zero));
    chk("count", b.instr_count, m_cnt);
    chk("cause", b.cause, m_cause);
  end

  int st[7], pw[7], rw[7], m2[7], ep[7], ps[7];
  // run one instruction with run pulsed for its FETCH only, recording the per-cycle trace
  task automatic instr(input logic [5:0] op, input bit z, input bit o);
    @(posedge clk);
    #2 b.run = 1'b1;
    b.opcode = op;
    b.alu_zero = z;
    b.alu_ovf = o;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      st[i] = b.state;
      pw[i] = b.pc_write;
      rw[i] = b.reg_write;
      m2[i] = b.mem2reg;
      ep[i] = b.epc_write;
      ps[i] = b.pc_src;
      if (i == 0) begin
        @(posedge clk);
        #2 b.run = 1'b0;
      end
    end
  endtask

  logic [5:0] ops[7] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02};
  int lw_seq[6] = '{0, 1, 2, 3, 4, 0};
  initial begin
    SYS_reset = 1'b1;
    b.run = 1'b0;
    b.opcode = 6'h00;
    b.alu_zero = 1'b0;
    b.alu_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #2 SYS_reset = 1'b0;
    chk("reset_state", b.state, 0);
    chk("reset_count", b.instr_count, 0);
    instr(6'h23, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) chk($sformatf("lw_state%0d", i), st[i], lw_seq[i]);
    chk("lw_regwrite_wb", rw[4], 1);
    chk("lw_mem2reg_wb", m2[4], 1);
    chk("lw_regwrite_rd", rw[3], 0);
    chk("lw_count", b.instr_count, 1);
    instr(6'h04, 1'b1, 1'b0);
    chk("beq_taken_state", st[2], 10);
    chk("beq_taken_pcw", pw[2], 1);
    chk("beq_taken_pcsrc", ps[2], 1);
    instr(6'h04, 1'b0, 1'b0);
    chk("beq_nt_pcw", pw[2], 0);
    instr(6'h05, 1'b0, 1'b0);
    chk("bne_taken_pcw", pw[2], 1);
    instr(6'h05, 1'b1, 1'b0);
    chk("bne_nt_pcw", pw[2], 0);
    chk("branch_count", b.instr_count, 5);
    instr(6'h00, 1'b0, 1'b1);
`ifdef MULTICYCLE_CTRL_EXC_EN
    chk("rovf_state", st[3], 12);
    chk("rovf_epc", ep[3], 1);
    chk("rovf_regwrite", rw[3], 0);
    chk("rovf_cause", b.cause, 2);
    chk("rovf_count", b.instr_count, 5);
`else
    chk("rovf_state", st[3], 7);
    chk("rovf_regwrite", rw[3], 1);
    chk("rovf_count", b.instr_count, 6);
`endif
    instr(6'h3F, 1'b0, 1'b0);
`ifdef MULTICYCLE_CTRL_EXC_EN
    chk("undef_state", st[2], 12);
    chk("undef_cause", b.cause, 1);
    chk("undef_count", b.instr_count, 5);
`else
    chk("undef_state", st[2], 0);
    chk("undef_pcw", pw[2], 0);
    chk("undef_count", b.instr_count, 6);
`endif
    @(posedge clk);
    #2 b.run = 1'b1;
    b.opcode = 6'h2B;
    @(posedge clk);
    #2 b.run = 1'b0;
    repeat (2) @(posedge clk);
    #3 chk("sw_memwr_state", b.state, 5);
    chk("sw_memwr_strobe", b.mem_write, 1);
    SYS_reset = 1'b1;
    #1 chk("async_rst_state", b.state, 0);
    chk("async_rst_memwrite", b.mem_write, 0);
    chk("async_rst_count", b.instr_count, 0);
    chk("async_rst_cause", b.cause, 0);
    b.run = 1'b1;
    @(negedge clk);
    chk("rst_held_pcw", b.pc_write, 0);
    @(posedge clk);
    #2 chk("rst_held_state", b.state, 0);
    SYS_reset = 1'b0;
    b.run = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall_state", b.state, 0);
    chk("stall_pcw", b.pc_write, 0);
    for (int i = 0; i < 17; i++) instr(6'h2B, 1'b0, 1'b0);
    chk("wrap_count", b.instr_count, 1);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (m_k == 0) begin
        b.run = ($urandom % 4) != 0;
        b.opcode = ($urandom % 8 == 7) ? 6'($urandom) : ops[$urandom % 7];
        b.alu_zero = 1'($urandom % 2);
        b.alu_ovf = ($urandom % 4) == 0;
      end else b.run = 1'($urandom % 2);
      if ($urandom % 300 == 0) begin
        SYS_reset = 1'b1;
        #1 SYS_reset = 1'b0;
      end
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 SYS_clk  in  1  clock; all state changes on rising edge.
REQ-003 SYS_reset  in  1  reset, asynchronous, active-high.
REQ-004 run  in  1  start/continue enable, sampled only in FETCH.
REQ-005 opcode  in  6  instruction[31:26] from the instruction register.
REQ-006 alu_zero  in  1  ALU zero flag, combinational, same cycle.
REQ-007 alu_ovf  in  1  ALU signed-overflow flag, combinational, same cycle.
REQ-008 state  out  4  current state code, per REQ-013.
REQ-009 pc_write, ir_write, reg_write, reg_dst, mem_read, mem_write, mem2reg, alu_src_a  out  1 each  datapath strobes/selects.
REQ-010 pc_src  out  2  next-PC select: 0 ALU result, 1 ALUOut (branch target), 2 jump address, 3 exception vector.
REQ-011 alu_src_b  out  2  ALU B select: 0 rt, 1 constant 4, 2 sign-extended imm, 3 imm<<2; alu_op  out  2  00 add, 01 sub, 10 use funct.
REQ-012 epc_write  out  1  capture-PC pulse; cause  out  2  0 none, 1 undefined opcode, 2 overflow; instr_done  out  1  retire pulse; instr_count  out  CNT_W  retired-instruction count.

Function
REQ-013 States, with codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, ITEX 8, ITWB 9, BRANCH 10, JUMP 11, EXC 12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-014 FETCH with run=0: stay in FETCH, all strobes 0 (stall).
REQ-015 FETCH with run=1: mem_read=1, ir_write=1, alu_src_a=0, alu_src_b=1, alu_op=00, pc_src=0, pc_write=1; go to DECODE.
REQ-016 DECODE: alu_src_a=0, alu_src_b=3, alu_op=00 (precompute branch target); next state by opcode: 0x00 RTEX, 0x23/0x2B MEMADR, 0x08 ITEX, 0x04/0x05 BRANCH, 0x02 JUMP, other EXC (cause 1).
REQ-017 MEMADR: alu_src_a=1, alu_src_b=2, alu_op=00; go to MEMRD for 0x23, MEMWR for 0x2B.
REQ-018 MEMRD: mem_read=1, go to MEMWB; MEMWB: reg_write=1, reg_dst=0, mem2reg=1, instr_done=1, go to FETCH.
REQ-019 MEMWR: mem_write=1, instr_done=1, go to FETCH.
REQ-020 RTEX: alu_src_a=1, alu_src_b=0, alu_op=10; go to EXC (cause 2) if alu_ovf=1, else RTWB. RTWB: reg_write=1, reg_dst=1, mem2reg=0, instr_done=1, go to FETCH.
REQ-021 ITEX: alu_src_a=1, alu_src_b=2, alu_op=00; go to EXC (cause 2) if alu_ovf=1, else ITWB. ITWB: reg_write=1, reg_dst=0, mem2reg=0, instr_done=1, go to FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1; pc_write=1 only if (opcode 0x04 and alu_zero) or (opcode 0x05 and !alu_zero); instr_done=1; go to FETCH.
REQ-023 JUMP: pc_src=2, pc_write=1, instr_done=1, go to FETCH.
REQ-024 EXC: epc_write=1, pc_src=3, pc_write=1, reg_write=0, mem_write=0, instr_done=0; go to FETCH.
REQ-025 All strobes not listed for a state SHALL be 0; outputs SHALL be a pure function of state, opcode and ALU flags (Moore strobes plus the REQ-022 conditional).
REQ-026 Latency in cycles from FETCH: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, exception 3 (undefined) or 4 (overflow).
REQ-027 cause SHALL update only on entry to EXC and hold until the next exception or reset.
REQ-028 instr_count SHALL increment by 1 on each instr_done and wrap from all-ones to 0.
REQ-029 run falling mid-instruction SHALL NOT stall; the instruction completes and the FSM then holds in FETCH.

Reset
REQ-030 SYS_reset=1 SHALL force state=FETCH, cause=0, instr_count=0 immediately, regardless of clock, including mid-instruction.
REQ-031 While SYS_reset=1, all strobes SHALL be 0; the first FETCH action occurs on the first rising edge after deassertion with run=1.

Configuration
REQ-032 Macro MULTICYCLE_CTRL_EXC_EN: defined SHALL enable state EXC and REQ-016/020/021/024/027 behaviour.
REQ-033 Without MULTICYCLE_CTRL_EXC_EN, undefined opcodes SHALL go DECODE->FETCH with no strobes and no instr_done, alu_ovf SHALL be ignored (RTEX->RTWB, ITEX->ITWB), and epc_write and cause SHALL be tied to 0.

Verification
REQ-034 Reset, run=1, opcode 0x23 -> states 0,1,2,3,4,0; reg_write and mem2reg high only in state 4; instr_count=1.
REQ-035 opcode 0x04 with alu_zero=1 -> pc_write=1, pc_src=1 in BRANCH; same with alu_zero=0 -> pc_write=0; opcode 0x05 gives the inverse.
REQ-036 opcode 0x00 with alu_ovf=1 in RTEX -> next state 12, epc_write=1, cause=2, no reg_write, instr_count unchanged; without the macro -> RTWB, reg_write=1.
REQ-037 opcode 0x3F -> EXC with cause=1 (macro on); macro off -> DECODE->FETCH, no strobes.
REQ-038 SYS_reset pulsed between clock edges during MEMWR -> state=0 and mem_write=0 at once; run=0 after reset -> FETCH held, pc_write=0.
REQ-039 CNT_W=4, retire 17 sw instructions -> instr_count=1 (wrap).
